// File: rtl/proj_qsys_memory_arbiter_if.sv
// ============================================================================
// Module   : proj_qsys_memory_arbiter_if
// Purpose  : Bus bundle for the two-requester shared-memory arbiter.
//            Carries both requester command/response channels and the
//            muxed memory-side port.
//            slave  modport: the arbiter.
//            master modport: the requesters and memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface proj_qsys_memory_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  // Requester 0
  logic [ADDR_W-1:0]   m0_address;
  logic [DATA_W/8-1:0] m0_byteenable;
  logic                m0_read;
  logic                m0_write;
  logic [DATA_W-1:0]   m0_writedata;
  logic                m0_waitrequest;
  logic [DATA_W-1:0]   m0_readdata;
  logic                m0_readdatavalid;
  // Requester 1
  logic [ADDR_W-1:0]   m1_address;
  logic [DATA_W/8-1:0] m1_byteenable;
  logic                m1_read;
  logic                m1_write;
  logic [DATA_W-1:0]   m1_writedata;
  logic                m1_waitrequest;
  logic [DATA_W-1:0]   m1_readdata;
  logic                m1_readdatavalid;
  // Shared memory port
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_chipselect;
  logic                mem_write;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_writedata,
    output mem_chipselect, mem_write, mem_clken,
    input  mem_readdata
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_writedata,
    input  mem_chipselect, mem_write, mem_clken,
    output mem_readdata
  );
endinterface

`default_nettype wire

// File: rtl/proj_qsys_memory_arbiter.sv
// ============================================================================
// Module   : proj_qsys_memory_arbiter
// Purpose  : Two-requester arbiter in front of a single-port on-chip memory
//            with one-cycle read latency. Combinational round-robin grant,
//            hold counter to bound consecutive grants under contention,
//            registered issuer tag to steer read data back.
// Options  : PROJ_QSYS_MEMARB_FIXED_PRIORITY_EN - m0 always wins contention;
//            the hold counter still guarantees m1 a slot.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module proj_qsys_memory_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input wire clk,
  input wire reset,
  proj_qsys_memory_arbiter_if.slave bus
);

  localparam int            BE_W     = DATA_W / 8;
  localparam logic [3:0]    HOLD_LIM = 4'(MAX_HOLD);

  // Arbitration state: priority pointer, last winner, run-length counter
  logic       ptr_q,   ptr_d;
  logic       last_q,  last_d;
  logic [3:0] hold_q,  hold_d;
  // Read return tracking: issuer tag and valid flag
  logic       rd_tag_q,   rd_tag_d;
  logic       rd_valid_q, rd_valid_d;

  logic              req0, req1;
  logic              grant;
  logic              winner;      // 0 = m0, 1 = m1
  logic              sel_read;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic [DATA_W-1:0] sel_writedata;

  // Grant decision and next-state computation
  always_comb begin
    req0       = bus.m0_read | bus.m0_write;
    req1       = bus.m1_read | bus.m1_write;
    grant      = 1'b0;
    winner     = 1'b0;
    ptr_d      = ptr_q;
    last_d     = last_q;
    hold_d     = 4'd0;
    rd_tag_d   = rd_tag_q;
    rd_valid_d = 1'b0;

    if (!reset) begin
      if (req0 && req1) begin
        grant = 1'b1;
        // A full run forces the other requester in, whatever the pointer says
        if (hold_q >= HOLD_LIM) winner = ~last_q;
        else                    winner = ptr_q;
      end else if (req0) begin
        grant  = 1'b1;
        winner = 1'b0;
      end else if (req1) begin
        grant  = 1'b1;
        winner = 1'b1;
      end
    end

    sel_read       = winner ? bus.m1_read       : bus.m0_read;
    sel_write      = winner ? bus.m1_write      : bus.m0_write;
    sel_address    = winner ? bus.m1_address    : bus.m0_address;
    sel_byteenable = winner ? bus.m1_byteenable : bus.m0_byteenable;
    sel_writedata  = winner ? bus.m1_writedata  : bus.m0_writedata;

    if (grant) begin
`ifdef PROJ_QSYS_MEMARB_FIXED_PRIORITY_EN
      ptr_d = 1'b0;
`else
      ptr_d = ~winner;
`endif
      last_d = winner;
      // Counter holds the length of the current run under contention; a
      // switch starts a new run of length one.
      if (req0 && req1) hold_d = (winner == last_q) ? hold_q + 4'd1 : 4'd1;
      rd_tag_d   = winner;
      rd_valid_d = sel_read;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= 1'b0;
      last_q     <= 1'b0;
      hold_q     <= 4'd0;
      rd_tag_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      rd_tag_q   <= rd_tag_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Memory-side command mux
  assign bus.mem_address    = sel_address;
  assign bus.mem_byteenable = sel_byteenable;
  assign bus.mem_writedata  = sel_writedata;
  assign bus.mem_chipselect = grant;
  assign bus.mem_write      = grant & sel_write;
  assign bus.mem_clken      = ~reset;

  // Requester responses; read data is an unregistered fan-out of memory data
  assign bus.m0_waitrequest   = ~(grant & ~winner);
  assign bus.m1_waitrequest   = ~(grant &  winner);
  assign bus.m0_readdata      = bus.mem_readdata;
  assign bus.m1_readdata      = bus.mem_readdata;
  assign bus.m0_readdatavalid = rd_valid_q & ~rd_tag_q;
  assign bus.m1_readdatavalid = rd_valid_q &  rd_tag_q;

endmodule

`default_nettype wire

// File: tb/tb_proj_qsys_memory_arbiter.sv
// ============================================================================
// Module   : tb_proj_qsys_memory_arbiter
// Purpose  : Directed self-checking bench for proj_qsys_memory_arbiter with a
//            behavioural 2048 x 32 single-port memory (one-cycle read).
//            Honours PROJ_QSYS_MEMARB_FIXED_PRIORITY_EN for the contention
//            pattern.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_proj_qsys_memory_arbiter;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  proj_qsys_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  proj_qsys_memory_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: byte-lane writes, registered read output
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mem_rd;
  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write) begin
        for (int b = 0; b < DATA_W/8; b++)
          if (bus.mem_byteenable[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      end else begin
        mem_rd <= mem[bus.mem_address];
      end
    end
  end
  assign bus.mem_readdata = mem_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m0_cmd(input logic rd, input logic wr, input logic [10:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
    bus.m0_byteenable = be; bus.m0_writedata = wd;
  endtask

  task automatic m1_cmd(input logic rd, input logic wr, input logic [10:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
    bus.m1_byteenable = be; bus.m1_writedata = wd;
  endtask

  // Move to the next cycle's low phase; inputs change here, checks follow #1
  task automatic next_cycle();
    @(negedge clk);
  endtask

  int prev_g;
  int exp_g;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    m0_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    m1_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);

    // Reset held three cycles with both requesting
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      m0_cmd(1'b1, 1'b0, 11'h010, 4'hF, 32'h0);
      m1_cmd(1'b1, 1'b0, 11'h7FF, 4'hF, 32'h0);
      #1;
      chk("rst_wait0", bus.m0_waitrequest, 1'b1);
      chk("rst_wait1", bus.m1_waitrequest, 1'b1);
      chk("rst_cs",    bus.mem_chipselect, 1'b0);
      chk("rst_we",    bus.mem_write,      1'b0);
      chk("rst_clken", bus.mem_clken,      1'b0);
      if (i > 0) begin
        chk("rst_rdv0", bus.m0_readdatavalid, 1'b0);
        chk("rst_rdv1", bus.m1_readdatavalid, 1'b0);
      end
    end

    // Idle after reset: waitrequest high, no access
    next_cycle();
    reset = 1'b0;
    m0_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    m1_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1;
    chk("idle_clken", bus.mem_clken,      1'b1);
    chk("idle_wait0", bus.m0_waitrequest, 1'b1);
    chk("idle_wait1", bus.m1_waitrequest, 1'b1);
    chk("idle_cs",    bus.mem_chipselect, 1'b0);
    chk("idle_rdv0",  bus.m0_readdatavalid, 1'b0);

    // m0 write then read-back of the same address
    next_cycle();
    m0_cmd(1'b0, 1'b1, 11'h005, 4'hF, 32'hDEADBEEF);
    #1;
    chk("wr_wait0", bus.m0_waitrequest, 1'b0);
    chk("wr_cs",    bus.mem_chipselect, 1'b1);
    chk("wr_we",    bus.mem_write,      1'b1);
    chk("wr_addr",  bus.mem_address,    11'h005);
    chk("wr_wdata", bus.mem_writedata,  32'hDEADBEEF);
    next_cycle();
    m0_cmd(1'b1, 1'b0, 11'h005, 4'hF, 32'h0);
    #1;
    chk("rd_wait0", bus.m0_waitrequest, 1'b0);
    chk("rd_we",    bus.mem_write,      1'b0);
    chk("wr_nordv", bus.m0_readdatavalid, 1'b0);
    next_cycle();
    m0_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1;
    chk("rd_rdv0",  bus.m0_readdatavalid, 1'b1);
    chk("rd_data0", bus.m0_readdata,      32'hDEADBEEF);
    chk("rd_rdv1",  bus.m1_readdatavalid, 1'b0);

    // Preload; m1 writes last so the pointer favours m0 next
    next_cycle();
    m0_cmd(1'b0, 1'b1, 11'h010, 4'hF, 32'hA5A50010);
    next_cycle();
    m0_cmd(1'b0, 1'b1, 11'h020, 4'hF, 32'h11223344);
    next_cycle();
    m0_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    m1_cmd(1'b0, 1'b1, 11'h7FF, 4'hF, 32'h5A5A07FF);
    #1;
    chk("pre_wait1", bus.m1_waitrequest, 1'b0);
    chk("pre_addr1", bus.mem_address,    11'h7FF);

    // Contention: both read continuously
    prev_g = 2;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      m0_cmd(1'b1, 1'b0, 11'h010, 4'hF, 32'h0);
      m1_cmd(1'b1, 1'b0, 11'h7FF, 4'hF, 32'h0);
      #1;
`ifdef PROJ_QSYS_MEMARB_FIXED_PRIORITY_EN
      exp_g = ((i % (MAX_HOLD + 1)) == MAX_HOLD) ? 1 : 0;
`else
      exp_g = i % 2;
`endif
      chk("cont_wait0", bus.m0_waitrequest, exp_g != 0);
      chk("cont_wait1", bus.m1_waitrequest, exp_g == 0);
      chk("cont_addr",  bus.mem_address,    (exp_g == 0) ? 11'h010 : 11'h7FF);
      chk("cont_rdv0",  bus.m0_readdatavalid, prev_g == 0);
      chk("cont_rdv1",  bus.m1_readdatavalid, prev_g == 1);
      if (prev_g == 0) chk("cont_data0", bus.m0_readdata, 32'hA5A50010);
      if (prev_g == 1) chk("cont_data1", bus.m1_readdata, 32'h5A5A07FF);
      prev_g = exp_g;
    end
    next_cycle();
    m0_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    m1_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1;
    chk("tail_rdv0", bus.m0_readdatavalid, prev_g == 0);
    chk("tail_rdv1", bus.m1_readdatavalid, prev_g == 1);
    chk("tail_data", bus.m1_readdata, (prev_g == 0) ? 32'hA5A50010 : 32'h5A5A07FF);

    // Byte-lane write merges into existing word
    next_cycle();
    m0_cmd(1'b0, 1'b1, 11'h020, 4'h1, 32'h000000AA);
    #1;
    chk("bw_be", bus.mem_byteenable, 4'h1);
    next_cycle();
    m0_cmd(1'b1, 1'b0, 11'h020, 4'hF, 32'h0);
    next_cycle();
    m0_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1;
    chk("bw_rdv0", bus.m0_readdatavalid, 1'b1);
    chk("bw_data", bus.m0_readdata,      32'h112233AA);

    // Reset in the cycle of a read: nothing accepted, no data returned
    next_cycle();
    reset = 1'b1;
    m0_cmd(1'b1, 1'b0, 11'h005, 4'hF, 32'h0);
    #1;
    chk("rr_wait0", bus.m0_waitrequest, 1'b1);
    chk("rr_cs",    bus.mem_chipselect, 1'b0);
    next_cycle();
    reset = 1'b0;
    m0_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1;
    chk("rr_rdv0", bus.m0_readdatavalid, 1'b0);
    chk("rr_rdv1", bus.m1_readdatavalid, 1'b0);

    // After reset m0 has priority; both reads return in order
    next_cycle();
    m0_cmd(1'b1, 1'b0, 11'h005, 4'hF, 32'h0);
    m1_cmd(1'b1, 1'b0, 11'h7FF, 4'hF, 32'h0);
    #1;
    chk("pr_wait0", bus.m0_waitrequest, 1'b0);
    chk("pr_wait1", bus.m1_waitrequest, 1'b1);
    next_cycle();
    m0_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1;
    chk("pr_wait1b", bus.m1_waitrequest,   1'b0);
    chk("pr_rdv0",   bus.m0_readdatavalid, 1'b1);
    chk("pr_data0",  bus.m0_readdata,      32'hDEADBEEF);
    next_cycle();
    m1_cmd(1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1;
    chk("pr_rdv1",  bus.m1_readdatavalid, 1'b1);
    chk("pr_rdv0b", bus.m0_readdatavalid, 1'b0);
    chk("pr_data1", bus.m1_readdata,      32'h5A5A07FF);

    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/proj_qsys_memory_arbiter.md
PROJ_QSYS_MEMORY_ARBITER -- requirements
Module: proj_qsys_memory_arbiter

Interface
REQ-001 Parameter: ADDR_W, 11, word address width of the shared on-chip memory (2048 words).
REQ-002 Parameter: DATA_W, 32, data width; byteenable width SHALL be DATA_W/8.
REQ-003 Parameter: MAX_HOLD, 4, maximum consecutive grants to one requester while the other is requesting (1..15).
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 m0_address / m1_address  in  ADDR_W  requester word address.
REQ-007 m0_byteenable / m1_byteenable  in  DATA_W/8  write byte lanes.
REQ-008 m0_read, m0_write / m1_read, m1_write  in  1 each  command strobes; read and write SHALL NOT be asserted together by a requester.
REQ-009 m0_writedata / m1_writedata  in  DATA_W  write data.
REQ-010 m0_waitrequest / m1_waitrequest  out  1  command not accepted this cycle.
REQ-011 m0_readdata / m1_readdata  out  DATA_W  read data.
REQ-012 m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle.
REQ-013 mem_address  out  ADDR_W; mem_byteenable  out  DATA_W/8; mem_writedata  out  DATA_W  muxed command to memory.
REQ-014 mem_chipselect, mem_write  out  1  memory access / write enable.
REQ-015 mem_clken  out  1  memory clock enable; mem_readdata  in  DATA_W  memory output, valid one cycle after a read is issued.

Function
REQ-016 Requester n is requesting when mn_read or mn_write is high; a command is accepted in the cycle its waitrequest is low.
REQ-017 Arbitration SHALL be combinational each cycle; at most one requester granted per cycle; the granted requester's waitrequest low, the other's high while it requests.
REQ-018 An idle requester's waitrequest SHALL be high (no command pending, nothing accepted).
REQ-019 Round-robin: a priority pointer (reset value m0) SHALL select the winner when both request; after a grant the pointer SHALL point to the other requester.
REQ-020 Single requester: granted every cycle, back-to-back, regardless of pointer, subject to REQ-021.
REQ-021 Hold counter (4 bits) counts consecutive grants to the same requester while the other requests; at MAX_HOLD the other requester SHALL be granted next cycle and the counter clear; counter clears on any grant switch or cycle where the other does not request.
REQ-022 Granted cycle: mem_chipselect=1, mem_write=granted write strobe, mem_address/byteenable/writedata from the winner; no grant: mem_chipselect=0, mem_write=0.
REQ-023 Read latency: for a read accepted in cycle N, mn_readdatavalid SHALL be high in cycle N+1 for the issuing requester only, with mn_readdata=mem_readdata; a 1-bit issuer tag and valid flag are registered in cycle N.
REQ-024 Back-to-back reads from alternating requesters SHALL return in issue order, one per cycle, no bubbles.
REQ-025 Writes produce no readdatavalid; write-then-read same address on consecutive cycles SHALL return the new data.
REQ-026 mn_readdata SHALL equal mem_readdata whenever readdatavalid is low (don't-care value, no extra register).
REQ-027 mem_clken SHALL equal ~reset.

Reset
REQ-028 While reset is high: mem_chipselect=0, mem_write=0, both waitrequest=1, both readdatavalid=0 in the following cycle, pointer=m0, hold counter=0.
REQ-029 A read accepted the cycle reset asserts SHALL NOT produce readdatavalid; the tag/valid register clears.
REQ-030 First cycle after reset deasserts: arbitration resumes with m0 priority.

Configuration
REQ-031 Macro PROJ_QSYS_MEMARB_FIXED_PRIORITY_EN: when defined, m0 SHALL always win contention (pointer fixed at m0) with REQ-021 still preventing m1 starvation; when undefined, round-robin per REQ-019.

Verification
REQ-032 Reset held 3 cycles, both requesting -> both waitrequest=1, mem_chipselect=0, no readdatavalid.
REQ-033 m0 writes 0xDEADBEEF, byteenable 0xF, to addr 0x005; next cycle m0 reads 0x005 -> m0_readdatavalid one cycle later with 0xDEADBEEF; m1_readdatavalid stays 0.
REQ-034 Both read continuously (m0 addr 0x010, m1 addr 0x7FF) -> grants alternate m0,m1,m0,...; each readdatavalid pulses every other cycle with correct data.
REQ-035 With FIXED_PRIORITY_EN, MAX_HOLD=4, both requesting -> m0 granted 4 cycles, m1 1 cycle, repeating.
REQ-036 Byte write 0x000000AA, byteenable 0x1 to addr holding 0x11223344 -> read returns 0x112233AA.
REQ-037 Reset asserted in cycle a read is accepted -> no readdatavalid next cycle; normal read after reset returns correct data.
